// File: rtl/pll_rst_seq.sv
// PLL lock supervisor: synchronises and filters LOCK, re-pulses the PLL reset on timeout,
// and releases staggered per-channel resets. Optional SOFT_RST input under PLL_RST_SEQ_SOFT_RST_EN.
module pll_rst_seq #(
  parameter int NUM_CH       = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_FILT    = 64,
  parameter int CH_GAP       = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int PLL_RST_CYC  = 8,
  parameter int CNT_W        = 8
) (
  input  logic              CLKI,
  input  logic              RST,
  input  logic              LOCK_IN,
  input  logic              LOSS_CNT_CLR,
`ifdef PLL_RST_SEQ_SOFT_RST_EN
  input  logic              SOFT_RST,
`endif
  output logic              PLL_RST,
  output logic [NUM_CH-1:0] CH_RST,
  output logic              READY,
  output logic [CNT_W-1:0]  LOSS_CNT,
  output logic [2:0]        STATE
);

  localparam int REL_LAST = (NUM_CH - 1) * CH_GAP;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max_of(max_of(LOCK_TIMEOUT, LOCK_FILT),
                                  max_of(PLL_RST_CYC, REL_LAST + 1));
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_FILT   = 3'd2,
    ST_REL    = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               pll_rst_q;
  logic [NUM_CH-1:0]  ch_rst_q;
  logic               ready_q;
  logic [CNT_W-1:0]   loss_q;
  logic [CNT_W-1:0]   loss_d;
  logic               lock_s;
  logic               loss_ev;
  logic               soft_rst;

`ifdef PLL_RST_SEQ_SOFT_RST_EN
  assign soft_rst = SOFT_RST;
`else
  assign soft_rst = 1'b0;
`endif

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign loss_ev = ((state_q == ST_REL) || (state_q == ST_RUN)) && !lock_s;

  // Clear beats a coincident loss; soft reset suppresses counting of a coincident loss.
  always_comb begin
    loss_d = loss_q;
    if (LOSS_CNT_CLR)
      loss_d = '0;
    else if (loss_ev && !soft_rst && (loss_q != {CNT_W{1'b1}}))
      loss_d = loss_q + 1'b1;
  end

  always_ff @(posedge CLKI or posedge RST) begin
    if (RST)
      sync_q <= '0;
    else
      sync_q <= {sync_q[SYNC_STAGES-2:0], LOCK_IN};
  end

  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      state_q   <= ST_PLLRST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      ch_rst_q  <= '1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
    end else begin
      loss_q <= loss_d;
      if (soft_rst) begin
        state_q   <= ST_PLLRST;
        cnt_q     <= '0;
        pll_rst_q <= 1'b1;
        ch_rst_q  <= '1;
        ready_q   <= 1'b0;
      end else if (loss_ev) begin
        state_q  <= ST_WAIT;
        cnt_q    <= '0;
        ch_rst_q <= '1;
        ready_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_PLLRST: begin
            ch_rst_q <= '1;
            ready_q  <= 1'b0;
            if (cnt_q == CW'(PLL_RST_CYC - 1)) begin
              state_q   <= ST_WAIT;
              pll_rst_q <= 1'b0;
              cnt_q     <= '0;
            end else begin
              pll_rst_q <= 1'b1;
              cnt_q     <= cnt_q + 1'b1;
            end
          end
          ST_WAIT: begin
            if (lock_s) begin
              state_q <= ST_FILT;
              cnt_q   <= '0;
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
              state_q   <= ST_PLLRST;
              pll_rst_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_FILT: begin
            if (!lock_s) begin
              state_q <= ST_WAIT;
              cnt_q   <= '0;
            end else if (cnt_q == CW'(LOCK_FILT - 1)) begin
              state_q <= ST_REL;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_REL: begin
            // Channel i drops when the release counter reaches i*CH_GAP, so order is ascending.
            for (int i = 0; i < NUM_CH; i++) begin
              if (cnt_q == CW'(i * CH_GAP))
                ch_rst_q[i] <= 1'b0;
            end
            if (cnt_q == CW'(REL_LAST)) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_RUN: begin
            ch_rst_q <= '0;
            ready_q  <= 1'b1;
          end
          default: begin
            state_q   <= ST_PLLRST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            ch_rst_q  <= '1;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign PLL_RST  = pll_rst_q;
  assign CH_RST   = ch_rst_q;
  assign READY    = ready_q;
  assign LOSS_CNT = loss_q;
  assign STATE    = state_q;

endmodule
